// File: rtl/taxi_apb_arb_rr_if.sv
// APB bundle carrying N select lanes; N=1 is a plain APB link. The slave-side
// return path shares one read-data bus across all lanes.
interface taxi_apb_arb_rr_if #(
    parameter int N      = 1,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int STRB_W = DATA_W/8
);
    logic [N-1:0]        psel;
    logic [N-1:0]        penable;
    logic [N-1:0]        pwrite;
    logic [N*ADDR_W-1:0] paddr;
    logic [N*DATA_W-1:0] pwdata;
    logic [N*STRB_W-1:0] pstrb;
    logic [N*3-1:0]      pprot;
    logic [N-1:0]        pready;
    logic [DATA_W-1:0]   prdata;
    logic [N-1:0]        pslverr;

    modport master (
        output psel, penable, pwrite, paddr, pwdata, pstrb, pprot,
        input  pready, prdata, pslverr
    );

    modport slave (
        input  psel, penable, pwrite, paddr, pwdata, pstrb, pprot,
        output pready, prdata, pslverr
    );
endinterface

// File: rtl/taxi_apb_arb_rr.sv
// Round-robin arbiter sharing one APB master among PORTS requesters, fully registered.
// Optional access-phase timeout: define TAXI_APB_ARB_TIMEOUT_EN.
module taxi_apb_arb_rr #(
    parameter int PORTS   = 2,
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int STRB_W  = DATA_W/8,
    parameter int TIMEOUT = 1024
) (
    input  logic clk,
    input  logic rst_n,
    taxi_apb_arb_rr_if.slave  s_apb,
    taxi_apb_arb_rr_if.master m_apb
);

    localparam int PTR_W = (PORTS > 1) ? $clog2(PORTS) : 1;

    if (PORTS < 1 || PORTS > 16) begin : g_bad_ports
        $fatal(1, "taxi_apb_arb_rr: PORTS must be 1..16");
    end
    if (DATA_W != STRB_W*8) begin : g_bad_strb
        $fatal(1, "taxi_apb_arb_rr: DATA_W must equal STRB_W*8");
    end
    if (TIMEOUT < 0) begin : g_bad_timeout
        $fatal(1, "taxi_apb_arb_rr: TIMEOUT must not be negative");
    end

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

    state_t state, state_next;

    logic [PTR_W-1:0]  rr_ptr, grant, grant_sel, ptr_next;
    logic [PORTS-1:0]  req, grant_oh;
    logic              found;
    int                idx;
    logic              sel_write;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;
    logic [STRB_W-1:0] sel_strb;
    logic [2:0]        sel_prot;
    logic              timeout, done, resp_err;
    logic [DATA_W-1:0] resp_data;

    logic              psel_r, penable_r, pwrite_r;
    logic [ADDR_W-1:0] paddr_r;
    logic [DATA_W-1:0] pwdata_r;
    logic [STRB_W-1:0] pstrb_r;
    logic [2:0]        pprot_r;
    logic [PORTS-1:0]  pready_r, pslverr_r;
    logic [DATA_W-1:0] prdata_r;

`ifdef TAXI_APB_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT+1);

    if (TIMEOUT < 1) begin : g_bad_timeout_en
        $fatal(1, "taxi_apb_arb_rr: TIMEOUT must be at least 1");
    end

    logic [CNT_W-1:0] to_cnt;

    // Counts ACCESS cycles that ended without pready; cleared while in SETUP.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            to_cnt <= '0;
        end else if (state == SETUP) begin
            to_cnt <= '0;
        end else if (state == ACCESS && !m_apb.pready[0]) begin
            to_cnt <= to_cnt + 1'b1;
        end
    end

    assign timeout = (to_cnt == CNT_W'(TIMEOUT-1)) && !m_apb.pready[0];
`else
    assign timeout = 1'b0;
`endif

    assign req      = s_apb.psel & s_apb.penable;
    assign grant_oh = PORTS'(1) << grant;
    assign done     = (state == ACCESS) && (m_apb.pready[0] || timeout);
    // A real pready wins over a timeout landing in the same cycle.
    assign resp_err  = m_apb.pready[0] ? m_apb.pslverr[0] : 1'b1;
    assign resp_data = (pwrite_r || !m_apb.pready[0]) ? '0 : m_apb.prdata;

    // Rotating search: first requester at or after rr_ptr, wrapping to 0.
    always_comb begin
        found     = 1'b0;
        idx       = 0;
        grant_sel = '0;
        sel_write = 1'b0;
        sel_addr  = '0;
        sel_wdata = '0;
        sel_strb  = '0;
        sel_prot  = '0;
        for (int k = 0; k < PORTS; k++) begin
            idx = (int'(rr_ptr) + k) % PORTS;
            if (!found && req[idx]) begin
                found     = 1'b1;
                grant_sel = PTR_W'(idx);
                sel_write = s_apb.pwrite[idx];
                sel_addr  = s_apb.paddr[idx*ADDR_W +: ADDR_W];
                sel_wdata = s_apb.pwdata[idx*DATA_W +: DATA_W];
                sel_strb  = s_apb.pstrb[idx*STRB_W +: STRB_W];
                sel_prot  = s_apb.pprot[idx*3 +: 3];
            end
        end
        ptr_next = (int'(grant_sel) == PORTS-1) ? '0 : grant_sel + 1'b1;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (found) state_next = SETUP;
            SETUP:   state_next = ACCESS;
            ACCESS:  if (done) state_next = RESP;
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            rr_ptr    <= '0;
            grant     <= '0;
            psel_r    <= 1'b0;
            penable_r <= 1'b0;
            pwrite_r  <= 1'b0;
            paddr_r   <= '0;
            pwdata_r  <= '0;
            pstrb_r   <= '0;
            pprot_r   <= '0;
            pready_r  <= '0;
            pslverr_r <= '0;
            prdata_r  <= '0;
        end else begin
            state <= state_next;
            case (state)
                IDLE: begin
                    if (found) begin
                        grant     <= grant_sel;
                        rr_ptr    <= ptr_next;
                        pwrite_r  <= sel_write;
                        paddr_r   <= sel_addr;
                        pwdata_r  <= sel_wdata;
                        pstrb_r   <= sel_strb;
                        pprot_r   <= sel_prot;
                        psel_r    <= 1'b1;
                        penable_r <= 1'b0;
                    end
                end
                SETUP: penable_r <= 1'b1;
                ACCESS: begin
                    if (done) begin
                        psel_r    <= 1'b0;
                        penable_r <= 1'b0;
                        prdata_r  <= resp_data;
                        pready_r  <= grant_oh;
                        pslverr_r <= resp_err ? grant_oh : '0;
                    end
                end
                RESP: begin
                    pready_r  <= '0;
                    pslverr_r <= '0;
                end
                default: ;
            endcase
        end
    end

    assign m_apb.psel    = psel_r;
    assign m_apb.penable = penable_r;
    assign m_apb.pwrite  = pwrite_r;
    assign m_apb.paddr   = paddr_r;
    assign m_apb.pwdata  = pwdata_r;
    assign m_apb.pstrb   = pstrb_r;
    assign m_apb.pprot   = pprot_r;
    assign s_apb.pready  = pready_r;
    assign s_apb.pslverr = pslverr_r;
    assign s_apb.prdata  = prdata_r;

endmodule

// File: tb/tb_taxi_apb_arb_rr.sv
// Bench for taxi_apb_arb_rr: directed scenarios then randomized rounds against a
// transaction-level round-robin model.
module tb_taxi_apb_arb_rr;
    localparam int PORTS = 2, ADDR_W = 32, DATA_W = 32, STRB_W = 4, TIMEOUT = 16;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    taxi_apb_arb_rr_if #(.N(PORTS), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .STRB_W(STRB_W)) s_if ();
    taxi_apb_arb_rr_if #(.N(1), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .STRB_W(STRB_W)) m_if ();

    taxi_apb_arb_rr #(
        .PORTS(PORTS), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .STRB_W(STRB_W), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk), .rst_n(rst_n), .s_apb(s_if), .m_apb(m_if)
    );

    int vectors = 0, miscompares = 0;
    int rr = 0;
    bit pend[PORTS], sonly[PORTS];
    logic wr[PORTS];
    logic [31:0] addr[PORTS], wdat[PORTS];
    logic [3:0] strb[PORTS];
    logic [2:0] prot[PORTS];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic drive_port(input int p);
        s_if.psel[p]    = pend[p] | sonly[p];
        s_if.penable[p] = pend[p];
        s_if.pwrite[p]  = wr[p];
        s_if.paddr[p*ADDR_W +: ADDR_W]  = addr[p];
        s_if.pwdata[p*DATA_W +: DATA_W] = wdat[p];
        s_if.pstrb[p*STRB_W +: STRB_W]  = strb[p];
        s_if.pprot[p*3 +: 3]            = prot[p];
    endtask

    task automatic new_req(input int p, input logic w, input logic [31:0] a, input logic [31:0] d,
                           input logic [3:0] s, input logic [2:0] pr);
        wr[p] = w; addr[p] = a; wdat[p] = d; strb[p] = s; prot[p] = pr;
        pend[p] = 1'b1; sonly[p] = 1'b0;
        drive_port(p);
    endtask

    // Reference choice: first pending requester at or after rr, wrapping.
    function automatic int pick();
        for (int k = 0; k < PORTS; k++) begin
            if (pend[(rr + k) % PORTS]) return (rr + k) % PORTS;
        end
        return -1;
    endfunction

    // One arbitration round starting from an IDLE cycle.
    task automatic run_round(input int w, input logic [31:0] rdata, input logic err, input bit misbehave);
        int g;
        logic xwr;
        logic [31:0] exp_rd;
        g = pick();
        if (g < 0) begin
            tick();
            chk("idle_psel", m_if.psel, 0);
            chk("idle_pready", s_if.pready, 0);
            return;
        end
        rr = (g + 1) % PORTS;
        xwr = wr[g];
        tick();
        chk("setup_psel", m_if.psel, 1);
        chk("setup_penable", m_if.penable, 0);
        chk("m_pwrite", m_if.pwrite, wr[g]);
        chk("m_paddr", m_if.paddr, addr[g]);
        chk("m_pwdata", m_if.pwdata, wdat[g]);
        chk("m_pstrb", m_if.pstrb, strb[g]);
        chk("m_pprot", m_if.pprot, prot[g]);
        if (misbehave) begin
            pend[g] = 1'b0;
            drive_port(g);
        end
        tick();
        chk("access_psel", m_if.psel, 1);
        chk("access_penable", m_if.penable, 1);
        for (int i = 0; i < w; i++) begin
            tick();
            chk("wait_penable", m_if.penable, 1);
            chk("wait_pready", s_if.pready, 0);
        end
        m_if.pready = 1'b1; m_if.prdata = rdata; m_if.pslverr = err;
        tick();
        exp_rd = xwr ? 32'h0 : rdata;
        chk("resp_pready", s_if.pready, 1 << g);
        chk("resp_pslverr", s_if.pslverr, err ? (1 << g) : 0);
        chk("resp_prdata", s_if.prdata, exp_rd);
        chk("resp_psel", m_if.psel, 0);
        chk("resp_penable", m_if.penable, 0);
        m_if.pready = 1'b0; m_if.prdata = $urandom; m_if.pslverr = 1'($urandom % 2);
        pend[g] = 1'b0;
        drive_port(g);
        tick();
        chk("post_pready", s_if.pready, 0);
        chk("post_pslverr", s_if.pslverr, 0);
        chk("prdata_hold", s_if.prdata, exp_rd);
    endtask

    initial begin
        int g, got, w;
        s_if.psel = '0; s_if.penable = '0; s_if.pwrite = '0; s_if.paddr = '0;
        s_if.pwdata = '0; s_if.pstrb = '0; s_if.pprot = '0;
        m_if.pready = 1'b0; m_if.prdata = '0; m_if.pslverr = 1'b0;
        for (int p = 0; p < PORTS; p++) begin
            pend[p] = 0; sonly[p] = 0; wr[p] = 0; addr[p] = 0; wdat[p] = 0; strb[p] = 0; prot[p] = 0;
        end

        tick(); tick();
        chk("rst_m_psel", m_if.psel, 0);
        chk("rst_m_penable", m_if.penable, 0);
        chk("rst_m_paddr", m_if.paddr, 0);
        chk("rst_s_pready", s_if.pready, 0);
        chk("rst_s_pslverr", s_if.pslverr, 0);
        chk("rst_s_prdata", s_if.prdata, 0);
        rst_n = 1'b1;
        tick();

        // Simultaneous writes after reset: port 0 then port 1.
        new_req(0, 1'b1, 32'h4, 32'h1111_1111, 4'hf, 3'd0);
        new_req(1, 1'b1, 32'h8, 32'h2222_2222, 4'hf, 3'd1);
        run_round(0, 32'h0, 1'b0, 1'b0);
        run_round(0, 32'h0, 1'b0, 1'b0);

        new_req(0, 1'b0, 32'h10, 32'h0, 4'hf, 3'd2);
        run_round(0, 32'hDEAD_BEEF, 1'b0, 1'b0);

        new_req(1, 1'b0, 32'h20, 32'h0, 4'hf, 3'd0);
        run_round(5, 32'hCAFE_0123, 1'b0, 1'b0);

        new_req(0, 1'b1, 32'h30, 32'hA5A5_5A5A, 4'b0101, 3'd3);
        run_round(0, 32'h0, 1'b1, 1'b0);

        // Reset in the middle of ACCESS, after port 0 advanced the pointer.
        new_req(0, 1'b0, 32'h100, 32'h0, 4'hf, 3'd0);
        tick();
        chk("pre_rst_psel", m_if.psel, 1);
        tick();
        rst_n = 1'b0;
        #1;
        chk("async_rst_psel", m_if.psel, 0);
        chk("async_rst_penable", m_if.penable, 0);
        chk("async_rst_pready", s_if.pready, 0);
        for (int p = 0; p < PORTS; p++) begin
            pend[p] = 0; sonly[p] = 0; drive_port(p);
        end
        rr = 0;
        tick();
        rst_n = 1'b1;
        tick();
        new_req(0, 1'b0, 32'h200, 32'h0, 4'hf, 3'd0);
        new_req(1, 1'b0, 32'h300, 32'h0, 4'hf, 3'd0);
        run_round(0, 32'h1234_5678, 1'b0, 1'b0);
        run_round(1, 32'h8765_4321, 1'b0, 1'b0);

        // Slave never answers.
        new_req(1, 1'b0, 32'h400, 32'h0, 4'hf, 3'd0);
        g = pick();
        rr = (g + 1) % PORTS;
        tick(); tick();
        got = 0;
        for (int i = 1; i <= 40 && got == 0; i++) begin
            tick();
            if (s_if.pready != 0) got = i;
        end
`ifdef TAXI_APB_ARB_TIMEOUT_EN
        chk("timeout_cycles", got, TIMEOUT);
        chk("timeout_pready", s_if.pready, 1 << g);
        chk("timeout_pslverr", s_if.pslverr, 1 << g);
        chk("timeout_prdata", s_if.prdata, 0);
        pend[g] = 0; drive_port(g);
        tick();
        chk("timeout_idle_psel", m_if.psel, 0);
`else
        chk("no_timeout_cycles", got, 0);
        chk("no_timeout_penable", m_if.penable, 1);
        m_if.pready = 1'b1; m_if.prdata = 32'h0BAD_F00D; m_if.pslverr = 1'b0;
        tick();
        chk("late_pready", s_if.pready, 1 << g);
        chk("late_prdata", s_if.prdata, 32'h0BAD_F00D);
        m_if.pready = 1'b0;
        pend[g] = 0; drive_port(g);
        tick();
        chk("late_idle_pready", s_if.pready, 0);
`endif

        // Randomized rounds: new requests, drops before grant, setup-only noise.
        for (int r = 0; r < 150; r++) begin
            for (int p = 0; p < PORTS; p++) begin
                if (pend[p] && ($urandom % 8 == 0)) begin
                    pend[p] = 0; sonly[p] = 0;
                end else if (!pend[p] && ($urandom % 2 == 0)) begin
                    wr[p] = 1'($urandom % 2); addr[p] = $urandom; wdat[p] = $urandom;
                    strb[p] = 4'($urandom); prot[p] = 3'($urandom);
                    pend[p] = 1; sonly[p] = 0;
                end else if (!pend[p]) begin
                    sonly[p] = ($urandom % 4 == 0);
                end
                drive_port(p);
            end
            w = ($urandom % 5 == 0) ? int'($urandom_range(4, 8)) : int'($urandom_range(0, 2));
            run_round(w, $urandom, ($urandom % 4 == 0), ($urandom % 10 == 0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
